imem_loader: RTL and testbench

//  Writes program words into the instruction memory that the fetch controller reads. Receives a

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 16-bit words, writes them to instruction memory and releases cpu_hold once the image verifies.
module imem_loader #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned I_ADDR_W    = 7,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   output logic                mem_write,
   output logic [I_ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_data,
   output logic                cpu_hold,
   output logic                done,
   output logic                error,
   output logic [I_ADDR_W:0]   words_loaded
);

   localparam int unsigned Capacity = 2 ** I_ADDR_W;
   localparam int unsigned TmoW     = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StDataHi,
      StDataLo,
      StWrite,
      StCheck,
      StDone,
      StErr
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         len_q;
   logic [7:0]          hi_q;
   logic [7:0]          csum_q;
   logic [I_ADDR_W:0]   words_q;
   logic [TmoW-1:0]     tmo_q;
   logic                mem_write_q;
   logic [I_ADDR_W-1:0] mem_addr_q;
   logic [WIDTH-1:0]    mem_data_q;

   logic                accept;
   logic                start_ok;
   logic                tmo_hit;
   logic [15:0]         len_next;
   logic [15:0]         words_next;

   assign accept     = in_valid & in_ready;
   assign len_next   = {len_q[15:8], in_data};
   assign words_next = 16'(words_q) + 16'd1;
   assign start_ok   = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
   // in_ready doubles as "waiting for a byte", which is exactly when the idle timer runs
   assign tmo_hit    = in_ready & ~accept & (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) state_d = StLenHi;
         end
         StLenHi: begin
            if (accept) state_d = StLenLo;
         end
         StLenLo: begin
            if (accept) begin
               if (len_next == 16'd0) begin
                  state_d = StCheck;
               end else if (32'(len_next) > Capacity) begin
                  state_d = StErr;
               end else begin
                  state_d = StDataHi;
               end
            end
         end
         StDataHi: begin
            if (accept) state_d = StDataLo;
         end
         StDataLo: begin
            if (accept) state_d = StWrite;
         end
         StWrite: begin
            state_d = (words_next < len_q) ? StDataHi : StCheck;
         end
         StCheck: begin
            if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
         end
         default: state_d = StIdle;
      endcase
      if (tmo_hit) state_d = StErr;
   end

   // Output decode
   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      unique case (state_q)
         StLenHi, StLenLo, StDataHi, StDataLo, StCheck: in_ready = 1'b1;
         StDone:  done  = 1'b1;
         StErr:   error = 1'b1;
         default: ;
      endcase
      cpu_hold = ~done;
   end

   // Frame datapath: length, word assembly, running checksum, idle timer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q   <= '0;
         hi_q    <= '0;
         csum_q  <= '0;
         words_q <= '0;
         tmo_q   <= '0;
      end else if (start_ok) begin
         len_q   <= '0;
         csum_q  <= '0;
         words_q <= '0;
         tmo_q   <= '0;
      end else begin
         if (accept) begin
            tmo_q <= '0;
         end else if (in_ready) begin
            tmo_q <= tmo_q + TmoW'(1);
         end
         if (accept) begin
            unique case (state_q)
               StLenHi:  len_q[15:8] <= in_data;
               StLenLo:  len_q[7:0]  <= in_data;
               StDataHi: begin
                  hi_q   <= in_data;
                  csum_q <= csum_q ^ in_data;
               end
               StDataLo: csum_q <= csum_q ^ in_data;
               default: ;
            endcase
         end
         if (state_q == StWrite) words_q <= words_q + 1'b1;
      end
   end

   // Memory port is registered; loading it on entry to WRITE lines the strobe up with that state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
      end else begin
         mem_write_q <= (state_d == StWrite);
         if (state_d == StWrite) begin
            mem_addr_q <= words_q[I_ADDR_W-1:0];
            mem_data_q <= WIDTH'({hi_q, in_data});
         end
      end
   end

   assign mem_write    = mem_write_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data     = mem_data_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, length corner cases, checksum, timeout, reset abort.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_write;
   logic [6:0]  mem_addr;
   logic [15:0] mem_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [7:0]  words_loaded;

   int tests = 0;
   int fails = 0;

   logic [15:0] mem_model [0:127];
   int          wr_count;
   int          busy_write;
   logic [6:0]  last_addr;

   logic [7:0]  frame [0:299];
   int          frame_len;

   imem_loader #(
      .WIDTH       (16),
      .I_ADDR_W    (7),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-side monitor
   always @(negedge clk) begin
      if (mem_write) begin
         mem_model[mem_addr] <= mem_data;
         wr_count            <= wr_count + 1;
         last_addr           <= mem_addr;
         if (in_ready) busy_write <= busy_write + 1;
      end
   end

   task automatic clear_monitor();
      wr_count   = 0;
      busy_write = 0;
      for (int i = 0; i < 128; i++) mem_model[i] = 16'h0000;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 64 && !ok; i++) begin
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) ok = 1'b1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_byte: byte %02h not accepted within 64 cycles", b);
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frame_len; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         send_byte(frame[i]);
      end
   endtask

   task automatic load_t1(input logic [7:0] csum);
      frame[0] = 8'h00; frame[1] = 8'h02;
      frame[2] = 8'h12; frame[3] = 8'h34;
      frame[4] = 8'hAB; frame[5] = 8'hCD;
      frame[6] = csum;
      frame_len = 7;
   endtask

   task automatic test_reset();
      tests++;
      if ({in_ready, mem_write, mem_addr, mem_data, cpu_hold, done, error, words_loaded} !==
          {1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_outputs: rdy=%b wr=%b addr=%h data=%h hold=%b done=%b err=%b wl=%0d",
                  in_ready, mem_write, mem_addr, mem_data, cpu_hold, done, error, words_loaded);
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL idle_ready: got %b expected 0", in_ready);
      end
   endtask

   task automatic test_basic();
      clear_monitor();
      pulse_start();
      load_t1(8'h40);  // 12^34^AB^CD
      send_frame(1'b0);
      tests++;
      if (mem_model[0] !== 16'h1234 || mem_model[1] !== 16'hABCD) begin
         fails++;
         $display("FAIL t1_mem: got %h %h expected 1234 abcd", mem_model[0], mem_model[1]);
      end
      tests++;
      if ({done, error, cpu_hold} !== 3'b100) begin
         fails++;
         $display("FAIL t1_status: done/err/hold got %b expected 100", {done, error, cpu_hold});
      end
      tests++;
      if (words_loaded !== 8'd2 || wr_count != 2) begin
         fails++;
         $display("FAIL t1_count: words_loaded %0d writes %0d expected 2 2", words_loaded, wr_count);
      end
      // Same frame with a wrong checksum byte
      pulse_start();
      load_t1(8'h3E);
      send_frame(1'b0);
      tests++;
      if ({done, error, cpu_hold} !== 3'b011) begin
         fails++;
         $display("FAIL t1_badsum: done/err/hold got %b expected 011", {done, error, cpu_hold});
      end
   endtask

   task automatic test_zero_len();
      clear_monitor();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00; frame_len = 3;
      send_frame(1'b0);
      tests++;
      if (done !== 1'b1 || wr_count != 0) begin
         fails++;
         $display("FAIL t2_zero_ok: done %b writes %0d expected 1 0", done, wr_count);
      end
      pulse_start();
      frame[2] = 8'h01;
      send_frame(1'b0);
      tests++;
      if ({error, cpu_hold, done} !== 3'b110 || wr_count != 0) begin
         fails++;
         $display("FAIL t2_zero_bad: err/hold/done %b writes %0d expected 110 0",
                  {error, cpu_hold, done}, wr_count);
      end
   endtask

   task automatic test_length_limits();
      clear_monitor();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h81; frame_len = 2;
      send_frame(1'b0);
      tests++;
      if (error !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL t3_too_long: err %b rdy %b expected 1 0", error, in_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (wr_count != 0) begin
         fails++;
         $display("FAIL t3_no_write: writes %0d expected 0", wr_count);
      end
      clear_monitor();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h80;
      for (int i = 0; i < 128; i++) begin
         frame[2 + 2 * i] = 8'h00;
         frame[3 + 2 * i] = 8'(i);
      end
      frame[258] = 8'h00;  // XOR of 0..127 is zero
      frame_len  = 259;
      send_frame(1'b0);
      tests++;
      if (done !== 1'b1 || wr_count != 128 || last_addr !== 7'h7F) begin
         fails++;
         $display("FAIL t3_full: done %b writes %0d last %h expected 1 128 7f",
                  done, wr_count, last_addr);
      end
      tests++;
      if (mem_model[127] !== 16'h007F || mem_model[5] !== 16'h0005 || words_loaded !== 8'd128) begin
         fails++;
         $display("FAIL t3_full_data: [127]=%h [5]=%h wl=%0d expected 007f 0005 128",
                  mem_model[127], mem_model[5], words_loaded);
      end
   endtask

   task automatic test_gaps_badsum();
      clear_monitor();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h01; frame[2] = 8'h00; frame[3] = 8'h05; frame[4] = 8'h04;
      frame_len = 5;
      send_frame(1'b1);
      tests++;
      if (mem_model[0] !== 16'h0005 || wr_count != 1) begin
         fails++;
         $display("FAIL t4_data: [0]=%h writes %0d expected 0005 1", mem_model[0], wr_count);
      end
      tests++;
      if (busy_write != 0) begin
         fails++;
         $display("FAIL t4_ready_in_write: %0d write cycles with in_ready=1, expected 0", busy_write);
      end
      tests++;
      if (error !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL t4_error: err %b done %b expected 1 0", error, done);
      end
   endtask

   task automatic test_timeout();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h01; frame[2] = 8'h12; frame_len = 3;
      send_frame(1'b0);
      repeat (15) @(posedge clk);
      #1;
      tests++;
      if (error !== 1'b0) begin
         fails++;
         $display("FAIL t5_early: err %b after 15 idle cycles, expected 0", error);
      end
      @(posedge clk); #1;
      tests++;
      if (error !== 1'b1 || cpu_hold !== 1'b1) begin
         fails++;
         $display("FAIL t5_expire: err %b hold %b after 16 idle cycles, expected 1 1",
                  error, cpu_hold);
      end
   endtask

   task automatic test_reset_mid_load();
      clear_monitor();
      pulse_start();
      frame[0] = 8'h00; frame[1] = 8'h02; frame[2] = 8'h12; frame[3] = 8'h34; frame[4] = 8'hAB;
      frame_len = 5;
      send_frame(1'b0);
      reset = 1'b0;
      #1;
      tests++;
      if ({in_ready, mem_write, mem_addr, mem_data, cpu_hold, done, error, words_loaded} !==
          {1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL t6_abort: rdy=%b wr=%b addr=%h data=%h hold=%b done=%b err=%b wl=%0d",
                  in_ready, mem_write, mem_addr, mem_data, cpu_hold, done, error, words_loaded);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      clear_monitor();
      pulse_start();
      load_t1(8'h40);
      send_frame(1'b0);
      tests++;
      if (done !== 1'b1 || words_loaded !== 8'd2 || mem_model[1] !== 16'hABCD) begin
         fails++;
         $display("FAIL t6_reload: done %b wl %0d [1]=%h expected 1 2 abcd",
                  done, words_loaded, mem_model[1]);
      end
   endtask

   task automatic test_start_priority();
      // Sitting in DONE: start and a byte together; the byte must be dropped
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      tests++;
      if ({in_ready, done, cpu_hold} !== 3'b101 || words_loaded !== 8'd0) begin
         fails++;
         $display("FAIL start_clear: rdy/done/hold %b wl %0d expected 101 0",
                  {in_ready, done, cpu_hold}, words_loaded);
      end
      frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00; frame_len = 3;
      send_frame(1'b0);
      tests++;
      if (done !== 1'b1 || error !== 1'b0) begin
         fails++;
         $display("FAIL start_wins: done %b err %b expected 1 0", done, error);
      end
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clear_monitor();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_zero_len();
      test_length_limits();
      test_gaps_badsum();
      test_timeout();
      test_reset_mid_load();
      test_start_priority();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
